cnn_result_collector: RTL and testbench

Sink end of the crop_plus_gaussian output interface. It accepts the five independent per-class AXI-stream outputs (cnn_output_0..4) in any order and at any rate, captures one word per channel per run, and serialises them in index order 0..4 onto a single AXI-stream result port, with TLAST on the final word. It sits between crop_plus_gaussian and the downstream DMA/host. Run control uses the ap_start/ap_done/ap_idle/ap_ready convention already used by crop_plus_gaussian.

---
 rtl/cnn_collect_pkg.sv | 8 +
 rtl/cnn_result_collector_slot.sv | 31 +++
 rtl/cnn_result_collector.sv | 135 +++++++++++++
 tb/tb_cnn_result_collector.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_collect_pkg.sv
// cnn_collect_pkg: shared FSM states, channel count and drain-index type for the result collector.
package cnn_collect_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
    localparam int NUM_OUTPUTS_C = 5;
    localparam int IDX_W = 3;
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(NUM_OUTPUTS_C - 1);
endpackage

// File: rtl/cnn_result_collector_slot.sv
// axis_capture_slot: one-word AXI-stream capture register with a per-run captured flag.
// Ports: ap_clk/ap_rst clock and sync reset; enable (collecting) and clear (end of run);
// tdata/tvalid/tready stream sink; data/captured expose the stored word and its flag.
module axis_capture_slot #(
    parameter int W = 16
) (
    input  logic         ap_clk,
    input  logic         ap_rst,
    input  logic         enable,
    input  logic         clear,
    input  logic [W-1:0] tdata,
    input  logic         tvalid,
    output logic         tready,
    output logic [W-1:0] data,
    output logic         captured
);
    // Ready depends only on registers so upstream never sees a combinational loop through tvalid.
    assign tready = enable && !captured;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            data     <= '0;
            captured <= 1'b0;
        end else if (clear) begin
            captured <= 1'b0;
        end else if (tvalid && tready) begin
            data     <= tdata;
            captured <= 1'b1;
        end
    end
endmodule

// File: rtl/cnn_result_collector.sv
// cnn_result_collector: collects one word from each of five AXI-stream channels and replays them in index order.
// Ports: ap_clk/ap_rst clock and sync active-high reset; ap_start/ap_done/ap_idle/ap_ready run control;
// cnn_output_0..4_TDATA/TVALID/TREADY per-class sinks; result_TDATA/TUSER/TLAST/TVALID/TREADY serial source.
// Build option CNN_COLLECT_TIMEOUT_EN adds the TIMEOUT_CYCLES watchdog and the timeout_err output.
module cnn_result_collector
    import cnn_collect_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 16,
`ifdef CNN_COLLECT_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 65535,
`endif
    parameter int NUM_OUTPUTS = 5
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic                       ap_start,
    output logic                       ap_done,
    output logic                       ap_idle,
    output logic                       ap_ready,
`ifdef CNN_COLLECT_TIMEOUT_EN
    output logic                       timeout_err,
`endif
    input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_0_TDATA,
    input  logic                       cnn_output_0_TVALID,
    output logic                       cnn_output_0_TREADY,
    input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_1_TDATA,
    input  logic                       cnn_output_1_TVALID,
    output logic                       cnn_output_1_TREADY,
    input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_2_TDATA,
    input  logic                       cnn_output_2_TVALID,
    output logic                       cnn_output_2_TREADY,
    input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_3_TDATA,
    input  logic                       cnn_output_3_TVALID,
    output logic                       cnn_output_3_TREADY,
    input  logic [PIXEL_BIT_WIDTH-1:0] cnn_output_4_TDATA,
    input  logic                       cnn_output_4_TVALID,
    output logic                       cnn_output_4_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0] result_TDATA,
    output logic [2:0]                 result_TUSER,
    output logic                       result_TLAST,
    output logic                       result_TVALID,
    input  logic                       result_TREADY
);
    state_t                     state, state_n;
    idx_t                       idx;
    logic [NUM_OUTPUTS-1:0]     tvalid, tready, captured;
    logic [PIXEL_BIT_WIDTH-1:0] tdata [NUM_OUTPUTS];
    logic [PIXEL_BIT_WIDTH-1:0] data  [NUM_OUTPUTS];
    logic                       drain, last, all_cap, timeout_hit;

    assign tvalid   = {cnn_output_4_TVALID, cnn_output_3_TVALID, cnn_output_2_TVALID,
                       cnn_output_1_TVALID, cnn_output_0_TVALID};
    assign tdata[0] = cnn_output_0_TDATA;
    assign tdata[1] = cnn_output_1_TDATA;
    assign tdata[2] = cnn_output_2_TDATA;
    assign tdata[3] = cnn_output_3_TDATA;
    assign tdata[4] = cnn_output_4_TDATA;
    assign {cnn_output_4_TREADY, cnn_output_3_TREADY, cnn_output_2_TREADY,
            cnn_output_1_TREADY, cnn_output_0_TREADY} = tready;

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_slot
        axis_capture_slot #(.W(PIXEL_BIT_WIDTH)) u_slot (
            .ap_clk   (ap_clk),
            .ap_rst   (ap_rst),
            .enable   (state == COLLECT),
            .clear    (state == DONE),
            .tdata    (tdata[k]),
            .tvalid   (tvalid[k]),
            .tready   (tready[k]),
            .data     (data[k]),
            .captured (captured[k])
        );
    end

    assign all_cap = &captured;
    assign drain   = state == DRAIN;
    assign last    = idx == LAST_IDX;

    // A channel still uncaptured at drain time (only possible after a timeout) reads as zero
    // rather than exposing the stale word from an earlier run.
    assign result_TVALID = drain;
    assign result_TDATA  = (drain && captured[idx]) ? data[idx] : '0;
    assign result_TUSER  = drain ? idx : '0;
    assign result_TLAST  = drain && last;
    assign ap_idle       = state == IDLE;
    assign ap_done       = state == DONE;
    assign ap_ready      = ap_done;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = ap_start ? COLLECT : IDLE;
            COLLECT: state_n = (all_cap || timeout_hit) ? DRAIN : COLLECT;
            DRAIN:   state_n = (result_TREADY && last) ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            // Wrapping to zero on the final word leaves the index ready for the next run.
            if (drain && result_TREADY)
                idx <= last ? '0 : idx + idx_t'(1);
        end
    end

`ifdef CNN_COLLECT_TIMEOUT_EN
    localparam logic [15:0] TO_C = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt;

    assign timeout_hit = (state == COLLECT) && (cnt == TO_C) && !all_cap;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE && ap_start) begin
                cnt         <= '0;
                timeout_err <= 1'b0;
            end else if (state == COLLECT) begin
                cnt <= cnt + 16'd1;
            end
            if (timeout_hit)
                timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif
endmodule

// File: tb/tb_cnn_result_collector.sv
// tb_cnn_result_collector: directed self-checking bench for cnn_result_collector.
module tb_cnn_result_collector;
    logic        ap_clk, ap_rst, ap_start, ap_done, ap_idle, ap_ready;
    logic [15:0] td [5];
    logic        tv [5];
    logic [4:0]  rdy;
    logic [15:0] result_TDATA;
    logic [2:0]  result_TUSER;
    logic        result_TLAST, result_TVALID, result_TREADY;
`ifdef CNN_COLLECT_TIMEOUT_EN
    logic        timeout_err;
`endif

    int          total = 0, bad = 0;
    int          arr [5];
    logic [15:0] dv  [5];
    logic [15:0] gd  [8];
    logic [2:0]  gu  [8];
    logic        gl  [8];
    int          n, done_cnt, done_cyc, unstable, ready_after;
    bit          rst_hit;

    cnn_result_collector #(
        .PIXEL_BIT_WIDTH(16)
`ifdef CNN_COLLECT_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
`ifdef CNN_COLLECT_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .cnn_output_0_TDATA(td[0]), .cnn_output_0_TVALID(tv[0]), .cnn_output_0_TREADY(rdy[0]),
        .cnn_output_1_TDATA(td[1]), .cnn_output_1_TVALID(tv[1]), .cnn_output_1_TREADY(rdy[1]),
        .cnn_output_2_TDATA(td[2]), .cnn_output_2_TVALID(tv[2]), .cnn_output_2_TREADY(rdy[2]),
        .cnn_output_3_TDATA(td[3]), .cnn_output_3_TVALID(tv[3]), .cnn_output_3_TREADY(rdy[3]),
        .cnn_output_4_TDATA(td[4]), .cnn_output_4_TVALID(tv[4]), .cnn_output_4_TREADY(rdy[4]),
        .result_TDATA(result_TDATA), .result_TUSER(result_TUSER), .result_TLAST(result_TLAST),
        .result_TVALID(result_TVALID), .result_TREADY(result_TREADY)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    // Pulses ap_start, then for each cycle drives channel k from cycle arr[k] (negative: never)
    // until its handshake, and records result handshakes, ap_done pulses and protocol slips.
    task automatic run(input bit beef, input bit rnd, input bit spulse, input bit rst2, input int max_c);
        bit          cap [5];
        bit          pv, pr;
        logic [15:0] pd;
        logic [2:0]  pu;
        logic        pl;
        n = 0; done_cnt = 0; done_cyc = -1; unstable = 0; ready_after = 0; rst_hit = 0;
        pv = 0; pr = 0; pd = '0; pu = '0; pl = 0;
        for (int k = 0; k < 5; k++) cap[k] = 0;
        ap_start = 1; tick; ap_start = 0;
        for (int c = 1; c <= max_c; c++) begin
            for (int k = 0; k < 5; k++) begin
                if (cap[k]) begin
                    tv[k] = beef && k == 4;
                    td[k] = (beef && k == 4) ? 16'hBEEF : 16'h0;
                end else if (arr[k] >= 0 && c >= arr[k]) begin
                    tv[k] = 1; td[k] = dv[k];
                end else tv[k] = 0;
            end
            result_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (spulse) ap_start = (c == 2) || result_TVALID;
            if (ap_done) begin done_cnt++; done_cyc = c; end
            if (rst2 && result_TVALID && result_TUSER == 3'd2) begin
                ap_rst = 1; tick; rst_hit = 1;
                for (int k = 0; k < 5; k++) tv[k] = 0;
                return;
            end
            if (pv && !pr && (!result_TVALID || result_TDATA !== pd || result_TUSER !== pu || result_TLAST !== pl))
                unstable++;
            if (result_TVALID && result_TREADY && n < 8) begin
                gd[n] = result_TDATA; gu[n] = result_TUSER; gl[n] = result_TLAST; n++;
            end
            for (int k = 0; k < 5; k++) begin
                if (cap[k] && rdy[k]) ready_after++;
                if (tv[k] && rdy[k]) cap[k] = 1;
            end
            pv = result_TVALID; pr = result_TREADY; pd = result_TDATA; pu = result_TUSER; pl = result_TLAST;
            if (done_cyc > 0 && c >= done_cyc + 2) break;
            tick;
        end
        for (int k = 0; k < 5; k++) tv[k] = 0;
        ap_start = 0;
        result_TREADY = 1;
    endtask

    task automatic test_reset;
        ap_rst = 1; tick; tick;
        total++; if (result_TVALID !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", result_TVALID); end
        total++; if (result_TLAST !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b exp=0", result_TLAST); end
        total++; if (result_TUSER !== 3'd0) begin bad++; $display("FAIL reset_tuser got=%0d exp=0", result_TUSER); end
        total++; if (result_TDATA !== 16'h0) begin bad++; $display("FAIL reset_tdata got=%0h exp=0", result_TDATA); end
        total++; if (ap_done !== 1'b0 || ap_ready !== 1'b0) begin bad++; $display("FAIL reset_done got=%b%b exp=00", ap_done, ap_ready); end
        total++; if (ap_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", ap_idle); end
        total++; if (rdy !== 5'b0) begin bad++; $display("FAIL reset_tready got=%b exp=00000", rdy); end
`ifdef CNN_COLLECT_TIMEOUT_EN
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
`endif
        ap_rst = 0; tick;
    endtask

    task automatic check_words(input string tag);
        total++; if (n !== 5) begin bad++; $display("FAIL %s_count got=%0d exp=5", tag, n); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL %s_done_pulses got=%0d exp=1", tag, done_cnt); end
        for (int i = 0; i < 5; i++) begin
            total++; if (gd[i] !== dv[i]) begin bad++; $display("FAIL %s_data%0d got=%0h exp=%0h", tag, i, gd[i], dv[i]); end
            total++; if (gu[i] !== 3'(i)) begin bad++; $display("FAIL %s_user%0d got=%0d exp=%0d", tag, i, gu[i], i); end
            total++; if (gl[i] !== (i == 4)) begin bad++; $display("FAIL %s_last%0d got=%b exp=%b", tag, i, gl[i], i == 4); end
        end
    endtask

    task automatic test_basic;
        arr = '{1, 1, 1, 1, 1};
        dv  = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        run(0, 0, 0, 0, 40);
        check_words("basic");
        total++; if (done_cyc !== 8) begin bad++; $display("FAIL basic_latency got=%0d exp=8", done_cyc); end
    endtask

    task automatic test_out_of_order;
        arr = '{30, 50, 20, 40, 10};
        dv  = '{16'h0A10, 16'h0B11, 16'h0C12, 16'h0D13, 16'h0E14};
        run(1, 0, 0, 0, 120);
        check_words("ooo");
        total++; if (ready_after !== 0) begin bad++; $display("FAIL ooo_ready_after_capture got=%0d exp=0", ready_after); end
        total++; if (done_cyc !== 57) begin bad++; $display("FAIL ooo_latency got=%0d exp=57", done_cyc); end
    endtask

    task automatic test_backpressure;
        arr = '{1, 1, 1, 1, 1};
        dv  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        run(0, 1, 0, 0, 300);
        check_words("bp");
        total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stability got=%0d exp=0", unstable); end
    endtask

    task automatic test_reset_mid_drain;
        arr = '{1, 1, 1, 1, 1};
        dv  = '{16'h0055, 16'h0066, 16'h0077, 16'h0088, 16'h0099};
        run(0, 0, 0, 1, 40);
        total++; if (rst_hit !== 1'b1) begin bad++; $display("FAIL rst_reached_idx2 got=%b exp=1", rst_hit); end
        total++; if (n !== 2) begin bad++; $display("FAIL rst_words_before got=%0d exp=2", n); end
        total++; if (result_TVALID !== 1'b0 || result_TLAST !== 1'b0) begin bad++; $display("FAIL rst_valid_last got=%b%b exp=00", result_TVALID, result_TLAST); end
        total++; if (result_TUSER !== 3'd0 || result_TDATA !== 16'h0) begin bad++; $display("FAIL rst_user_data got=%0d/%0h exp=0/0", result_TUSER, result_TDATA); end
        total++; if (ap_idle !== 1'b1 || ap_done !== 1'b0 || rdy !== 5'b0) begin bad++; $display("FAIL rst_ctrl got=%b%b/%b exp=10/00000", ap_idle, ap_done, rdy); end
        ap_rst = 0; tick;
        dv = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
        run(0, 0, 0, 0, 40);
        check_words("rst_rerun");
    endtask

    task automatic test_back_to_back;
        arr = '{3, 3, 3, 3, 3};
        dv  = '{16'h0C00, 16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04};
        run(0, 0, 1, 0, 40);
        check_words("start_ignored");
        total++; if (done_cyc !== 10) begin bad++; $display("FAIL start_ignored_latency got=%0d exp=10", done_cyc); end
        arr = '{1, 1, 1, 1, 1};
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) dv[k] = 16'(16'h0100 * (r + 1) + k);
            run(0, 0, 0, 0, 40);
            check_words("b2b");
        end
    endtask

`ifdef CNN_COLLECT_TIMEOUT_EN
    task automatic test_timeout;
        arr = '{1, 1, 1, -1, 1};
        dv  = '{16'h0011, 16'h0022, 16'h0033, 16'h0000, 16'h0055};
        run(0, 0, 0, 0, 200);
        check_words("timeout");
        total++; if (done_cyc < 100 || done_cyc > 110) begin bad++; $display("FAIL timeout_latency got=%0d exp=100..110", done_cyc); end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err_set got=%b exp=1", timeout_err); end
        tick; tick; tick;
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err_held got=%b exp=1", timeout_err); end
        arr = '{1, 1, 1, 1, 1};
        dv  = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
        run(0, 0, 0, 0, 40);
        check_words("timeout_rerun");
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_err_cleared got=%b exp=0", timeout_err); end
    endtask
`endif

    initial begin
        ap_rst = 1; ap_start = 0; result_TREADY = 0;
        for (int k = 0; k < 5; k++) begin tv[k] = 0; td[k] = '0; end
        test_reset;
        test_basic;
        test_out_of_order;
        test_backpressure;
        test_reset_mid_drain;
        test_back_to_back;
`ifdef CNN_COLLECT_TIMEOUT_EN
        test_timeout;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
